// File: rtl/period_meter_pkg.sv
// Shared constants and state encoding for period_meter and related timing blocks.
package period_meter_pkg;

  // Oscillator frequency shared with the clock prescaler.
  localparam int unsigned F_OSC_DEFAULT = 25175000;

  typedef logic [0:0] state_t;

  localparam state_t ARMED   = 1'b0;
  localparam state_t MEASURE = 1'b1;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input, plus a delayed copy of the
// synchronized level so that single-cycle rise/fall strobes can be formed.
module period_meter_sync_edge_detect (
  input  logic clkin,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous input in clkin cycles,
// flagging a sticky timeout when no rising edge arrives within TIMEOUT_CYCLES.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned F_OSC          = F_OSC_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = F_OSC
) (
  input  logic        clkin,
  input  logic        rst,
  input  logic        sigin,
  output logic [31:0] period,
  output logic [31:0] high_time,
  output logic        valid,
  output logic        timeout
);

  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

  logic        level, rise, fall;
  logic        unused_level;
  logic [31:0] cnt, cnt_d;
  logic [31:0] hi_shadow;
  logic        fall_seen;
  state_t      state;

  period_meter_sync_edge_detect u_sync (
    .clkin (clkin),
    .rst   (rst),
    .din   (sigin),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign unused_level = level;

  // Saturates so a stuck input cannot wrap back into a plausible period.
  always_comb begin
    cnt_d = cnt;
    if (rise) begin
      cnt_d = 32'd1;
    end else if (cnt < TMO) begin
      cnt_d = cnt + 32'd1;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state     <= ARMED;
      cnt       <= 32'd0;
      hi_shadow <= 32'd0;
      fall_seen <= 1'b0;
      period    <= 32'd0;
      high_time <= 32'd0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      cnt   <= cnt_d;
      valid <= 1'b0;
      case (state)
        ARMED: begin
          if (rise) begin
            fall_seen <= 1'b0;
            state     <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            // A rise on the timeout cycle still completes the measurement.
            period    <= cnt;
            high_time <= fall_seen ? hi_shadow : cnt;
            valid     <= 1'b1;
            timeout   <= 1'b0;
            fall_seen <= 1'b0;
          end else begin
            if (fall && !fall_seen) begin
              hi_shadow <= cnt;
              fall_seen <= 1'b1;
            end
            if (cnt == TMO) begin
              state     <= ARMED;
              timeout   <= 1'b1;
              period    <= 32'd0;
              high_time <= 32'd0;
            end
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule
